// File: rtl/memory_access_stage.sv
// ============================================================================
// Module   : memory_access_stage
// Brief    : Memory-stage req/ack data-access controller with byte-lane select
//            and sign extension. Optional ack watchdog via MEM_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module memory_access_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] m_alu_result,
    input  logic [31:0] m_store_data,
    input  logic        m_mem_read,
    input  logic        m_mem_write,
    input  logic        m_byte,
    input  logic        w_stall,
    output logic [31:0] m_mem_data,
    output logic        m_stall,
    output logic        m_misaligned,
    output logic        m_bus_error,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       w_mem_op;
    logic       w_access;
    logic       w_req;
    logic       w_ack_hit;
    logic       w_timeout;
    logic [7:0] w_lane;

    assign w_mem_op  = m_mem_read | m_mem_write;
    assign w_access  = w_mem_op & ~m_misaligned;
    // Reset gates the request combinationally so it drops mid-cycle.
    assign w_req     = w_access & ~reset & (r_state != c_DONE);
    assign w_ack_hit = w_req & dmem_ack;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_access) begin
                    w_next_state = dmem_ack ? c_DONE : c_WAIT;
                end
            end
            c_WAIT: begin
                if (dmem_ack || w_timeout) begin
                    w_next_state = c_DONE;
                end
            end
            c_DONE: begin
                if (!w_stall) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        m_misaligned = w_mem_op & ~m_byte & (m_alu_result[1:0] != 2'b00);
        m_stall      = w_access & (r_state != c_DONE);
        dmem_req     = w_req;
        dmem_we      = w_req & m_mem_write;
        dmem_addr    = {m_alu_result[31:2], 2'b00};
        dmem_wdata   = m_byte ? {4{m_store_data[7:0]}} : m_store_data;
        dmem_be      = 4'h0;
        if (w_req) begin
            dmem_be = m_byte ? (4'b0001 << m_alu_result[1:0]) : 4'hF;
        end
    end

    always_comb begin
        case (m_alu_result[1:0])
            2'd0:    w_lane = dmem_rdata[7:0];
            2'd1:    w_lane = dmem_rdata[15:8];
            2'd2:    w_lane = dmem_rdata[23:16];
            default: w_lane = dmem_rdata[31:24];
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_mem_data <= 32'h0;
        end else if (w_ack_hit && m_mem_read) begin
            m_mem_data <= m_byte ? {{24{w_lane[7]}}, w_lane} : dmem_rdata;
        end else if (w_timeout) begin
            m_mem_data <= 32'h0;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_wait_count;
    logic       r_bus_error;

    // An ack in the final watchdog cycle takes priority over the abort.
    assign w_timeout = (r_state == c_WAIT) & ~dmem_ack &
                       (r_wait_count == c_TIMEOUT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wait_count <= 8'h0;
        end else if (r_state == c_WAIT && w_next_state == c_WAIT) begin
            r_wait_count <= r_wait_count + 8'h1;
        end else begin
            r_wait_count <= 8'h0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bus_error <= 1'b0;
        end else if (w_timeout) begin
            r_bus_error <= 1'b1;
        end else if (r_state == c_DONE && !w_stall) begin
            r_bus_error <= 1'b0;
        end
    end

    assign m_bus_error = r_bus_error;
`else
    assign w_timeout   = 1'b0;
    assign m_bus_error = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_memory_access_stage.sv
// ============================================================================
// Module   : tb_memory_access_stage
// Brief    : Directed self-checking bench for memory_access_stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_memory_access_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] m_alu_result = 32'h0;
    logic [31:0] m_store_data = 32'h0;
    logic        m_mem_read = 1'b0;
    logic        m_mem_write = 1'b0;
    logic        m_byte = 1'b0;
    logic        w_stall = 1'b0;
    logic [31:0] m_mem_data;
    logic        m_stall;
    logic        m_misaligned;
    logic        m_bus_error;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;

    int vectors = 0;
    int miscompares = 0;
    int st;

    memory_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .m_alu_result (m_alu_result),
        .m_store_data (m_store_data),
        .m_mem_read   (m_mem_read),
        .m_mem_write  (m_mem_write),
        .m_byte       (m_byte),
        .w_stall      (w_stall),
        .m_mem_data   (m_mem_data),
        .m_stall      (m_stall),
        .m_misaligned (m_misaligned),
        .m_bus_error  (m_bus_error),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] addr, input logic rd, input logic wr,
                             input logic bt, input logic [31:0] sdata);
        m_alu_result = addr;
        m_mem_read   = rd;
        m_mem_write  = wr;
        m_byte       = bt;
        m_store_data = sdata;
        #1;
    endtask

    task automatic clear_instr();
        m_mem_read  = 1'b0;
        m_mem_write = 1'b0;
        #1;
    endtask

    // Counts stall cycles; ack is raised in cycle ack_delay (negative = never).
    task automatic run_access(input logic [31:0] rdata, input int ack_delay, output int stalls);
        stalls = 0;
        for (int i = 0; i < 20 && m_stall; i++) begin
            stalls++;
            dmem_ack   = (i == ack_delay);
            dmem_rdata = rdata;
            tick();
        end
        dmem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        tick();
        tick();
        check("reset_data", m_mem_data, 32'h0);
        check("reset_req", {31'h0, dmem_req}, 32'h0);
        check("reset_stall", {31'h0, m_stall}, 32'h0);
        check("reset_buserr", {31'h0, m_bus_error}, 32'h0);
        reset = 1'b0;
        tick();

        // Word load, ack three cycles after the request
        set_instr(32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
        check("wl_req", {31'h0, dmem_req}, 32'h1);
        check("wl_be", {28'h0, dmem_be}, 32'hF);
        check("wl_addr", dmem_addr, 32'h100);
        check("wl_we", {31'h0, dmem_we}, 32'h0);
        run_access(32'hDEADBEEF, 3, st);
        check("wl_stalls", st, 32'd4);
        check("wl_data", m_mem_data, 32'hDEADBEEF);
        check("wl_done_req", {31'h0, dmem_req}, 32'h0);
        clear_instr();
        tick();

        // Byte loads: negative lanes and a positive lane
        set_instr(32'h103, 1'b1, 1'b0, 1'b1, 32'h0);
        check("bl3_be", {28'h0, dmem_be}, 32'h8);
        run_access(32'h80AABBCC, 0, st);
        check("bl3_stalls", st, 32'd1);
        check("bl3_data", m_mem_data, 32'hFFFFFF80);
        clear_instr();
        tick();
        set_instr(32'h101, 1'b1, 1'b0, 1'b1, 32'h0);
        run_access(32'h80AABBCC, 0, st);
        check("bl1_data", m_mem_data, 32'hFFFFFFBB);
        clear_instr();
        tick();
        set_instr(32'h100, 1'b1, 1'b0, 1'b1, 32'h0);
        run_access(32'h1234567F, 0, st);
        check("bl0_data", m_mem_data, 32'h0000007F);
        clear_instr();
        tick();

        // Byte store
        set_instr(32'h202, 1'b0, 1'b1, 1'b1, 32'h123456A5);
        check("bs_be", {28'h0, dmem_be}, 32'h4);
        check("bs_wdata", dmem_wdata, 32'hA5A5A5A5);
        check("bs_we", {31'h0, dmem_we}, 32'h1);
        check("bs_addr", dmem_addr, 32'h200);
        run_access(32'hFFFFFFFF, 1, st);
        check("bs_stalls", st, 32'd2);
        check("bs_data_hold", m_mem_data, 32'h0000007F);
        clear_instr();
        tick();

        // Misaligned word load
        set_instr(32'h102, 1'b1, 1'b0, 1'b0, 32'h0);
        check("mis_flag", {31'h0, m_misaligned}, 32'h1);
        check("mis_req", {31'h0, dmem_req}, 32'h0);
        check("mis_stall", {31'h0, m_stall}, 32'h0);
        tick();
        check("mis_req_later", {31'h0, dmem_req}, 32'h0);
        clear_instr();
        check("mis_clear", {31'h0, m_misaligned}, 32'h0);

        // Load completing under a 5-cycle writeback stall, then a store
        w_stall = 1'b1;
        set_instr(32'h104, 1'b1, 1'b0, 1'b0, 32'h0);
        run_access(32'h11223344, 0, st);
        for (int k = 0; k < 5; k++) begin
            check("ws_req", {31'h0, dmem_req}, 32'h0);
            check("ws_data", m_mem_data, 32'h11223344);
            if (k == 2) begin
                dmem_ack   = 1'b1;
                dmem_rdata = 32'hBAD0BAD0;
            end
            tick();
            dmem_ack = 1'b0;
        end
        w_stall = 1'b0;
        #1;
        check("ws_release_req", {31'h0, dmem_req}, 32'h0);
        tick();
        set_instr(32'h208, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D);
        check("ws_store_req", {31'h0, dmem_req}, 32'h1);
        check("ws_store_be", {28'h0, dmem_be}, 32'hF);
        check("ws_store_wdata", dmem_wdata, 32'hCAFEF00D);
        run_access(32'h0, 0, st);
        check("ws_store_data", m_mem_data, 32'h11223344);
        clear_instr();
        tick();

`ifdef MEM_TIMEOUT_EN
        // Watchdog abort after four WAIT cycles
        set_instr(32'h10C, 1'b1, 1'b0, 1'b0, 32'h0);
        run_access(32'h0, -1, st);
        check("to_stalls", st, 32'd5);
        check("to_buserr", {31'h0, m_bus_error}, 32'h1);
        check("to_data", m_mem_data, 32'h0);
        clear_instr();
        tick();
        check("to_buserr_clr", {31'h0, m_bus_error}, 32'h0);
`else
        check("no_buserr", {31'h0, m_bus_error}, 32'h0);
`endif

        // Reset in the middle of a WAIT
        set_instr(32'h110, 1'b1, 1'b0, 1'b0, 32'h0);
        run_access(32'h55AA55AA, 0, st);
        check("pre_rst_data", m_mem_data, 32'h55AA55AA);
        clear_instr();
        tick();
        set_instr(32'h114, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        check("rst_wait_req", {31'h0, dmem_req}, 32'h1);
        reset = 1'b1;
        #1;
        check("rst_req_drop", {31'h0, dmem_req}, 32'h0);
        check("rst_data", m_mem_data, 32'h0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hFFFFFFFF;
        tick();
        reset    = 1'b0;
        dmem_ack = 1'b0;
        clear_instr();
        tick();
        check("rst_late_ack", m_mem_data, 32'h0);
        check("rst_idle_req", {31'h0, dmem_req}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/memory_access_stage.md
# memory_access_stage

Memory-stage data-access controller between the execute-to-memory pipeline register and `memory_to_writeback`. It turns the instruction's load/store controls into a req/ack transaction on the data-memory port, and performs byte-lane selection and sign extension. It produces `m_mem_data` and `m_stall` for the downstream pipeline register, holding the stage stalled until the access completes.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: ack watchdog limit, 8-bit range 1..255; used only with `MEM_TIMEOUT_EN`.

Ports:
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `m_alu_result`  in  32  effective address.
- `m_store_data`  in  32  store operand (rt value).
- `m_mem_read`  in  1  instruction is a load.
- `m_mem_write`  in  1  instruction is a store; never set together with `m_mem_read`.
- `m_byte`  in  1  byte access (lb/sb) when 1, word access when 0.
- `w_stall`  in  1  writeback stage stalled; completed result must be held.
- `m_mem_data`  out  32  load result, registered, sign-extended for byte loads.
- `m_stall`  out  1  memory stage not ready; combinational.
- `m_misaligned`  out  1  word access with `addr[1:0]`≠0; combinational.
- `m_bus_error`  out  1  access aborted by the watchdog; registered, 0 without the macro.
- `dmem_req`  out  1  request valid.
- `dmem_we`  out  1  write enable.
- `dmem_addr`  out  32  word-aligned address (`{m_alu_result[31:2],2'b00}`).
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  write data.
- `dmem_ack`  in  1  transaction complete; `dmem_rdata` valid in the same cycle.
- `dmem_rdata`  in  32  read word.

## Operation
- `access = (m_mem_read | m_mem_write) & ~m_misaligned`.
- FSM states:
  - IDLE: if `access`, drive `dmem_req`. On `dmem_ack`, go to DONE; otherwise go to WAIT.
  - WAIT: keep `dmem_req` asserted with all request fields stable. On `dmem_ack`, go to DONE.
  - DONE: no request. If `w_stall`, stay in DONE. Otherwise return to IDLE, because the instruction leaves the stage on that edge.
- `m_stall = access & (state != DONE)`. A non-memory instruction gives `m_stall=0`, and the FSM stays in IDLE.
- Load capture on an ack edge:
  - Word load: `m_mem_data <= dmem_rdata`.
  - Byte load: select lane `addr[1:0]` with little-endian order (lane 0 = bits 7:0), then sign-extend to 32 bits.
- Stores: `m_mem_data` is unchanged.
- Store write data:
  - Word store: `dmem_be = 4'hF`, `dmem_wdata = m_store_data`.
  - Byte store: `dmem_be = 4'b0001 << addr[1:0]`, `dmem_wdata` = `m_store_data[7:0]` replicated ×4.
  - `dmem_we = m_mem_write`.
- `m_mem_data` holds its value whenever no load is being captured.
- Misaligned word access: no request is issued, `m_stall=0`, and `m_misaligned=1` while the instruction is present. The exception unit consumes it.
- Outputs driven 0 when no request is active: `dmem_req`, `dmem_we`, `dmem_be`.

## Timing
- Reset values: state IDLE, `m_mem_data=0`, `m_bus_error=0`, `dmem_req=0`, timeout counter 0.
- `reset` is asynchronous. Asserting it mid-transaction drops `dmem_req` in the same cycle, and a late `dmem_ack` is ignored.
- Minimum latency: 1 stall cycle.
  - Cycle 0: IDLE with req, ack arrives.
  - Cycle 1: DONE, `m_stall=0`, data valid.
  - A response with N wait cycles costs N+1 stall cycles.
- `dmem_ack` arriving while `dmem_req=0` is ignored.
- Back-to-back accesses: DONE→IDLE on the edge, and the next instruction's request is driven in the following cycle. There is no idle bubble beyond DONE.
- `w_stall` held high in DONE for K cycles: `m_mem_data` is stable for all K cycles and no new request is issued.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - An 8-bit counter runs while in WAIT and clears on leaving WAIT.
  - When the count reaches `TIMEOUT_CYCLES` without an ack, the FSM goes to DONE with `m_mem_data <= 0` and `m_bus_error <= 1`.
  - `m_bus_error` clears on the DONE→IDLE edge.
  - An ack in the same cycle as the timeout wins: data is captured and no error is raised.
- `MEM_TIMEOUT_EN` undefined: no counter is built, WAIT waits indefinitely, and `m_bus_error` is tied to 0.

## Test plan
- Word load, addr 0x100, ack 3 cycles after req, rdata 0xDEADBEEF:
  - `m_stall=1` for 4 cycles, then `m_mem_data=0xDEADBEEF`.
  - `dmem_be=4'hF`, `dmem_addr=0x100`.
- Byte load, addr 0x103, rdata 0x80AABBCC → `m_mem_data=0xFFFFFF80`. Same load at addr 0x101 → `0xFFFFFFBB`.
- Byte store, addr 0x202, data 0x123456A5 → `dmem_be=4'b0100`, `dmem_wdata=0xA5A5A5A5`, `dmem_we=1`, `dmem_addr=0x200`.
- Word load, addr 0x102 → `m_misaligned=1`, `dmem_req` stays 0, `m_stall=0`.
- Load completes while `w_stall=1` for 5 cycles:
  - Stays in DONE with data held and no new req.
  - A following store issues its request one cycle after `w_stall` falls.
- Reset during WAIT → `dmem_req=0` immediately, `m_mem_data=0`. With `MEM_TIMEOUT_EN` and `TIMEOUT_CYCLES=4`, no ack → `m_bus_error=1` and `m_mem_data=0` after 4 WAIT cycles.
